// File: rtl/iob_native_mem_responder_pkg.sv
// Shared definitions for the IOb native memory responder: request/response
// word layout, latency counter width and FSM state encoding.
package iob_native_mem_responder_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int req_w(input int aw, input int dw);
        return 1 + aw + dw + dw / 8;
    endfunction

    function automatic int resp_w(input int dw);
        return dw + 1;
    endfunction

    // Request word is {valid, addr, wdata, wstrb}; response word is {rdata, ready}.
    function automatic int wstrb_lsb();
        return 0;
    endfunction

    function automatic int wdata_lsb(input int dw);
        return dw / 8;
    endfunction

    function automatic int addr_lsb(input int dw);
        return dw / 8 + dw;
    endfunction

    function automatic int valid_pos(input int aw, input int dw);
        return dw / 8 + dw + aw;
    endfunction

    function automatic int ready_pos();
        return 0;
    endfunction

    function automatic int rdata_lsb();
        return 1;
    endfunction

endpackage

// File: rtl/iob_native_mem_responder_if.sv
// IOb native bus bundle between an initiator (master) and the memory responder (slave).
interface iob_native_mem_responder_if
    import iob_native_mem_responder_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int REQ_W  = req_w(ADDR_W, DATA_W);
    localparam int RESP_W = resp_w(DATA_W);

    logic [REQ_W-1:0]  req;
    logic [RESP_W-1:0] resp;
    logic              err;
    logic              err_clr;

    modport master (output req, output err_clr, input resp, input err);
    modport slave  (input req, input err_clr, output resp, output err);
endinterface

// File: rtl/iob_native_mem_responder_ram.sv
// Single-port RAM with per-byte write enables and a registered read port.
module iob_ram_sp_be #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic [DATA_W/8-1:0]   i_we,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_din,
    output logic [DATA_W-1:0]     o_dout
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_dout;

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_din[b*8 +: 8];
                end
            end
        end
    end

    // Only reads update the output register, so it holds between reads.
    always_ff @(posedge clk) begin
        if (i_en && (i_we == '0)) begin
            r_dout <= r_mem[i_addr];
        end
    end

    assign o_dout = r_dout;
endmodule

// File: rtl/iob_native_mem_responder.sv
// IOb native bus responder: services one request at a time from a byte-writable
// RAM and answers with a single-cycle ready pulse LATENCY cycles after capture.
module iob_native_mem_responder
    import iob_native_mem_responder_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int LATENCY    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    iob_native_mem_responder_if.slave  bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int REQ_W  = req_w(ADDR_W, DATA_W);

    logic              w_valid;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [STRB_W-1:0] w_wstrb;

    assign w_valid = bus.req[valid_pos(ADDR_W, DATA_W)];
    assign w_addr  = bus.req[addr_lsb(DATA_W) +: ADDR_W];
    assign w_wdata = bus.req[wdata_lsb(DATA_W) +: DATA_W];
    assign w_wstrb = bus.req[wstrb_lsb() +: STRB_W];

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [STRB_W-1:0]  r_wstrb;
    logic               r_zero;
    logic               r_err;
    logic               w_capture;
    logic               w_commit;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE, RESP: begin
                w_state_next = IDLE;
                if (w_valid) begin
                    w_capture  = 1'b1;
                    w_cnt_next = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        w_state_next = RESP;
                        w_commit     = 1'b1;
                    end else begin
                        w_state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = RESP;
                    w_commit     = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // With LATENCY==1 the commit edge is also the capture edge, so the live request is used.
    logic              w_direct;
    logic [ADDR_W-1:0] w_c_addr;
    logic [DATA_W-1:0] w_c_wdata;
    logic [STRB_W-1:0] w_c_wstrb;
    logic              w_in_range;
    logic              w_is_write;

    assign w_direct   = (r_state != WAIT);
    assign w_c_addr   = w_direct ? w_addr  : r_addr;
    assign w_c_wdata  = w_direct ? w_wdata : r_wdata;
    assign w_c_wstrb  = w_direct ? w_wstrb : r_wstrb;
    assign w_in_range = ((w_c_addr >> (MEM_ADDR_W + 2)) == '0);
    assign w_is_write = (w_c_wstrb != '0);

    logic [DATA_W-1:0] w_ram_dout;

    iob_ram_sp_be #(
        .ADDR_W (MEM_ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk    (clk),
        .i_en   (w_commit && w_in_range && !rst),
        .i_we   (w_c_wstrb),
        .i_addr (MEM_ADDR_W'(w_c_addr >> 2)),
        .i_din  (w_c_wdata),
        .o_dout (w_ram_dout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_zero  <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_capture) begin
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
                r_wstrb <= w_wstrb;
            end
            if (w_commit) begin
                r_zero <= w_is_write || !w_in_range;
            end
            if (w_commit && !w_in_range) begin
                r_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // Writes and out-of-range reads answer zero; the mask only changes on commit.
    assign bus.resp = {(r_zero ? {DATA_W{1'b0}} : w_ram_dout), (r_state == RESP)};
    assign bus.err  = r_err;
endmodule
